wshb_frame_slave: RTL and testbench



---
 rtl/wshb_frame_pkg.sv | 38 +++
 rtl/wshb_frame_ram.sv | 38 +++
 rtl/wshb_frame_slave.sv | 162 ++++++++++++++++
 tb/tb_wshb_frame_slave.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/wshb_frame_pkg.sv
// Shared types and the burst index stepping helper for the Wishbone frame slave.
package wshb_frame_pkg;

  typedef enum logic [2:0] {
    CtiClassic = 3'b000,
    CtiConst   = 3'b001,
    CtiIncr    = 3'b010,
    CtiEob     = 3'b111
  } cti_t;

  typedef enum logic [1:0] {
    BteLinear = 2'b00,
    BteWrap4  = 2'b01,
    BteWrap8  = 2'b10,
    BteWrap16 = 2'b11
  } bte_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StClassicAck,
    StBurst
  } state_t;

  // Wrapping bursts step only the low index bits; upper bits stay put.
  function automatic logic [31:0] next_index(input logic [31:0] idx, input bte_t bte);
    logic [31:0] nxt;
    nxt = idx;
    case (bte)
      BteWrap4:  nxt[1:0] = idx[1:0] + 2'd1;
      BteWrap8:  nxt[2:0] = idx[2:0] + 3'd1;
      BteWrap16: nxt[3:0] = idx[3:0] + 4'd1;
      default:   nxt      = idx + 32'd1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/wshb_frame_ram.sv
// Single-port DEPTH x 32 synchronous RAM with byte write enables and a one-cycle
// registered read port; only the read register is cleared by reset.
module wshb_frame_ram #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge sys_clk_i) begin
    if (req_i && we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_ni) begin
      rdata_q <= '0;
    end else if (req_i && !we_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wshb_frame_slave.sv
// Wishbone B4 slave fronting a word RAM: classic cycles, incrementing bursts, programmable
// first-access wait states. Define WSHB_FRAME_SLAVE_WRAP_EN to serve wrapping bursts.
module wshb_frame_slave
  import wshb_frame_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] dat_ms,
  input  logic [3:0]  sel,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  output logic [31:0] dat_sm,
  output logic        ack,
  output logic        err,
  output logic        rty
);

  localparam int unsigned       ADDR_W   = $clog2(DEPTH);
  localparam logic [32:0]       WinBytes = 33'(DEPTH) << 2;
  localparam logic [2:0]        WaitLast = 3'(WAIT_STATES - 1);
  localparam logic [ADDR_W-1:0] IdxLast  = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, req_idx, nxt_idx, ram_addr;
  logic [2:0]        wait_cnt_q;
  logic              we_q, burst_q, oor_q, ovf_q;
  bte_t              bte_q, bte_e;
  cti_t              cti_e;
  logic [31:0]       off;
  logic              in_range, wrap_ok, req_burst, req, adr_match, start, wait_done, beat;
  logic              ram_req, ram_we, at_last;

  assign off       = adr - BASE_ADR;
  assign in_range  = {1'b0, off} < WinBytes;
  assign req_idx   = off[ADDR_W+1:2];
  assign cti_e     = cti_t'(cti);
  assign bte_e     = bte_t'(bte);
`ifdef WSHB_FRAME_SLAVE_WRAP_EN
  assign wrap_ok   = 1'b1;
`else
  assign wrap_ok   = (bte_e == BteLinear);
`endif
  assign req_burst = in_range && (cti_e == CtiIncr) && wrap_ok;
  assign req       = cyc & stb;
  assign adr_match = off[31:2] == 30'(idx_q);
  assign wait_done = wait_cnt_q == WaitLast;
  assign nxt_idx   = ADDR_W'(next_index(32'(idx_q), bte_q));
  assign at_last   = (bte_q == BteLinear) && (idx_q == IdxLast);
  // A burst address that disagrees with the running index restarts as a fresh access.
  assign start     = req & ((state_q == StIdle) |
                            ((state_q == StBurst) & ~ovf_q & ~adr_match));
  assign beat      = (state_q == StBurst) & ack;
  assign rty       = 1'b0;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state_q <= StIdle;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!cyc) begin
      state_d = StIdle;
    end else if (start) begin
      if (WAIT_STATES == 0) state_d = req_burst ? StBurst : StClassicAck;
      else                  state_d = StWait;
    end else begin
      unique case (state_q)
        StWait:       if (wait_done) state_d = burst_q ? StBurst : StClassicAck;
        StClassicAck: if (stb) state_d = StIdle;
        StBurst:      if ((req & ovf_q) || (beat && cti_e == CtiEob)) state_d = StIdle;
        default:      ;
      endcase
    end
  end

  always_comb begin
    ack = 1'b0;
    err = 1'b0;
    unique case (state_q)
      StClassicAck: begin
        ack = req & ~oor_q;
        err = req & oor_q;
      end
      StBurst: begin
        ack = req & ~ovf_q & adr_match;
        err = req & ovf_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      idx_q      <= '0;
      wait_cnt_q <= '0;
      we_q       <= 1'b0;
      burst_q    <= 1'b0;
      oor_q      <= 1'b0;
      ovf_q      <= 1'b0;
      bte_q      <= BteLinear;
    end else if (start) begin
      idx_q      <= req_idx;
      wait_cnt_q <= '0;
      we_q       <= we;
      burst_q    <= req_burst;
      oor_q      <= ~in_range;
      ovf_q      <= 1'b0;
      bte_q      <= bte_e;
    end else begin
      if (state_q == StWait) wait_cnt_q <= wait_cnt_q + 3'd1;
      if (beat && cti_e != CtiEob) begin
        idx_q <= nxt_idx;
        ovf_q <= at_last;
      end
    end
  end

  // Reads are issued one cycle ahead of the ack that presents them; writes land in the ack cycle.
  always_comb begin
    ram_req  = 1'b0;
    ram_we   = 1'b0;
    ram_addr = idx_q;
    if (start) begin
      ram_addr = req_idx;
      ram_req  = (WAIT_STATES == 0) && in_range && !we;
    end else if (state_q == StWait) begin
      ram_req = cyc & wait_done & ~we_q & ~oor_q;
    end else if (ack) begin
      if (we_q) begin
        ram_req = sys_rst_n;
        ram_we  = 1'b1;
      end else if (state_q == StBurst) begin
        ram_req  = ~at_last;
        ram_addr = nxt_idx;
      end
    end
  end

  wshb_frame_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .sys_clk_i  (sys_clk),
    .sys_rst_ni (sys_rst_n),
    .req_i      (ram_req),
    .we_i       (ram_we),
    .be_i       (sel),
    .addr_i     (ram_addr),
    .wdata_i    (dat_ms),
    .rdata_o    (dat_sm)
  );

endmodule

// File: tb/tb_wshb_frame_slave.sv
// Directed bench for wshb_frame_slave: classic, byte-lane, burst, stall, range and reset cases.
module tb_wshb_frame_slave;

  localparam int unsigned DEPTH = 64;

  logic        sys_clk, sys_rst_n;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_ms, dat_sm;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack, err, rty;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [DEPTH];

  wshb_frame_slave #(
    .DEPTH       (DEPTH),
    .BASE_ADR    (32'h0000_0000),
    .WAIT_STATES (1)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cyc       (cyc),
    .stb       (stb),
    .we        (we),
    .adr       (adr),
    .dat_ms    (dat_ms),
    .sel       (sel),
    .cti       (cti),
    .bte       (bte),
    .dat_sm    (dat_sm),
    .ack       (ack),
    .err       (err),
    .rty       (rty)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Single access; ack2 samples the cycle after termination with the request still held.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] c, input logic [1:0] b,
                      output logic [31:0] rd, output int lat, output logic got_err,
                      output logic ack2);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_ms = d; sel = s; cti = c; bte = b;
    lat = -1; got_err = 1'b0; rd = '0; ack2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (ack || err) begin
        lat = i; got_err = err; rd = dat_sm;
        break;
      end
      tick();
    end
    tick();
    #2 ack2 = ack | err;
    tick();
    cyc = 1'b0; stb = 1'b0;
    tick();
  endtask

  task automatic wr(input string tag, input int word, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd; int lat; logic e, a2;
    xfer(1'b1, 32'(word * 4), d, s, 3'b000, 2'b00, rd, lat, e, a2);
    check({tag, "_lat"}, lat, 2);
    check({tag, "_err"}, e, 0);
    for (int k = 0; k < 4; k++) if (s[k]) model[word][8*k +: 8] = d[8*k +: 8];
  endtask

  task automatic rd_chk(input string tag, input int word);
    logic [31:0] rd; int lat; logic e, a2;
    xfer(1'b0, 32'(word * 4), 32'h0, 4'hf, 3'b000, 2'b00, rd, lat, e, a2);
    check({tag, "_lat"}, lat, 2);
    check({tag, "_dat"}, rd, model[word]);
  endtask

  task automatic burst(input string tag, input int start, input int n, input int stall_at,
                       input int stall_len, input int err_at, input int wrap);
    int b = 0;
    int stalled = 0;
    int word;
    cyc = 1'b1; we = 1'b0; sel = 4'hf;
    bte = (wrap == 4) ? 2'b01 : (wrap == 8) ? 2'b10 : (wrap == 16) ? 2'b11 : 2'b00;
    for (int t = 0; t < 60 && b < n; t++) begin
      word = (wrap != 0) ? ((start & ~(wrap - 1)) | ((start + b) & (wrap - 1))) : start + b;
      stb  = !(b == stall_at && stalled < stall_len);
      adr  = 32'(word * 4);
      cti  = (b == n - 1) ? 3'b111 : 3'b010;
      #2;
      if (!stb) begin
        check({tag, "_stall"}, ack | err, 0);
        stalled++;
      end else if (ack || err) begin
        check({tag, "_t"}, t, 2 + b + ((stall_at >= 0 && b >= stall_at) ? stall_len : 0));
        check({tag, "_ackerr"}, {ack, err}, (b == err_at) ? 2'b01 : 2'b10);
        if (b == err_at) check({tag, "_hold"}, dat_sm, model[word - 1]);
        else             check({tag, "_dat"}, dat_sm, model[word]);
        b++;
      end
      tick();
    end
    check({tag, "_beats"}, b, n);
    stb = 1'b0;
    #2 check({tag, "_end"}, ack | err, 0);
    tick();
    cyc = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, prev;
    int          lat;
    logic        e, a2;

    sys_rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_ms = '0;
    sel = '0; cti = '0; bte = '0;
    repeat (3) tick();
    sys_rst_n = 1'b1;
    #2;
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_rty", rty, 0);
    check("rst_dat", dat_sm, 0);
    tick();

    xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hf, 3'b000, 2'b00, rd, lat, e, a2);
    check("cw_lat", lat, 2);
    check("cw_err", e, 0);
    check("cw_one_wide", a2, 0);
    model[4] = 32'hDEAD_BEEF;
    rd_chk("cr", 4);
    wr("bw", 4, 32'h0000_00AA, 4'b0001);
    check("bw_model", model[4], 32'hDEAD_BEAA);
    rd_chk("br", 4);
    wr("sel0", 4, 32'h1234_5678, 4'b0000);
    rd_chk("sel0r", 4);

    // Out-of-range read: err at normal latency, read data held.
    prev = model[4];
    xfer(1'b0, 32'(DEPTH * 4), 32'h0, 4'hf, 3'b000, 2'b00, rd, lat, e, a2);
    check("oor_r_lat", lat, 2);
    check("oor_r_err", e, 1);
    check("oor_r_hold", rd, prev);

    for (int i = 0; i < 10; i++) wr("fill", i, 32'(i), 4'hf);
    wr("fillhi0", DEPTH - 2, 32'hA000_003E, 4'hf);
    wr("fillhi1", DEPTH - 1, 32'hA000_003F, 4'hf);

    xfer(1'b1, 32'(DEPTH * 4), 32'h0000_0055, 4'hf, 3'b000, 2'b00, rd, lat, e, a2);
    check("oor_w_lat", lat, 2);
    check("oor_w_err", e, 1);
    rd_chk("oor_w_nowrite", 0);

    burst("lin8", 0, 8, -1, 0, -1, 0);
    burst("stall", 0, 8, 3, 2, -1, 0);
    burst("edge", DEPTH - 2, 3, -1, 0, 2, 0);

    // cyc dropped during the wait state of a write.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h14; dat_ms = 32'hCAFE_F00D;
    sel = 4'hf; cti = 3'b000; bte = 2'b00;
    #2 check("drop_req", ack | err, 0);
    tick();
    cyc = 1'b0; stb = 1'b0;
    #2 check("drop_wait", ack | err, 0);
    tick();
    tick();
    rd_chk("drop_nowrite", 5);

    // Reset asserted during the first ack of a write burst.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h18; dat_ms = 32'hBAD0_BAD0;
    sel = 4'hf; cti = 3'b010; bte = 2'b00;
    tick();
    tick();
    #2 check("rstb_ack_before", ack, 1);
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1; cyc = 1'b0; stb = 1'b0;
    #2;
    check("rstb_ack", ack, 0);
    check("rstb_err", err, 0);
    check("rstb_dat", dat_sm, 0);
    tick();
    rd_chk("rstb_nowrite", 6);

`ifdef WSHB_FRAME_SLAVE_WRAP_EN
    burst("wrap4", 2, 4, -1, 0, -1, 4);
`else
    xfer(1'b0, 32'h8, 32'h0, 4'hf, 3'b010, 2'b01, rd, lat, e, a2);
    check("nowrap_lat", lat, 2);
    check("nowrap_dat", rd, model[2]);
    check("nowrap_single", a2, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
